// File: rtl/mmio_pkg.sv
// Register map constants and byte-lane helpers for the memory-mapped GPIO block.
package mmio_pkg;

    localparam int WINDOW_SIZE = 'h20;
    localparam int ADDR_W      = $clog2(WINDOW_SIZE);

    localparam logic [ADDR_W-1:0] ADDR_LEVEL  = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = 5'h04;
    localparam logic [ADDR_W-1:0] ADDR_OUT    = 5'h08;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE = 5'h0C;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = 5'h10;

    // Each field occupies one aligned 4-byte word; bits [1:0] pick the byte lane.
    function automatic logic is_field(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] base);
        return addr[ADDR_W-1:2] == base[ADDR_W-1:2];
    endfunction

    function automatic logic [7:0] field_byte(input logic [31:0] field, input logic [1:0] lane);
        return field[8*lane +: 8];
    endfunction

endpackage

// File: rtl/mmio_gpio_input_debouncer.sv
// One input channel: 2-flop synchroniser, stability counter, debounced level and rise pulse.
module input_debouncer
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // The cycle that completes the stable run both commits the new level and emits rise,
    // so the edge flag is set on the same clock as the level change.
    assign accept = (sync_q[1] != level) && (cnt_q == CNT_LAST);
    assign rise   = accept && sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= '0;
                level <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: debounced inputs with sticky rise flags and interrupt, byte-writable outputs.
module mmio_gpio
    import mmio_pkg::*;
#(
    parameter int N_IN            = 10,
    parameter int N_OUT           = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic [N_IN-1:0]   pins_in,
    output logic [N_OUT-1:0]  pins_out,
    output logic              irq
);

    logic [N_IN-1:0]  level;
    logic [N_IN-1:0]  rise;
    logic [N_IN-1:0]  edge_q;
    logic [N_IN-1:0]  irq_en_q;
    logic [N_OUT-1:0] out_q;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (pins_in[i]),
            .level  (level[i]),
            .rise   (rise[i])
        );
    end

    assign pins_out = out_q;

    logic wr_edge, wr_out, wr_toggle, wr_irq_en;

    assign wr_edge   = wr_en && is_field(addr, ADDR_EDGE);
    assign wr_out    = wr_en && is_field(addr, ADDR_OUT);
    assign wr_toggle = wr_en && is_field(addr, ADDR_TOGGLE);
    assign wr_irq_en = wr_en && is_field(addr, ADDR_IRQ_EN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q   <= '0;
            irq_en_q <= '0;
            out_q    <= '0;
            irq      <= 1'b0;
        end else begin
            irq <= |(edge_q & irq_en_q);
            // A rise in the same cycle as a W1C must survive, so it takes priority.
            for (int i = 0; i < N_IN; i++) begin
                if (rise[i]) begin
                    edge_q[i] <= 1'b1;
                end else if (wr_edge && addr[1:0] == 2'(i / 8) && wr_data[3'(i % 8)]) begin
                    edge_q[i] <= 1'b0;
                end
                if (wr_irq_en && addr[1:0] == 2'(i / 8)) begin
                    irq_en_q[i] <= wr_data[3'(i % 8)];
                end
            end
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_out && addr[1:0] == 2'(i / 8)) begin
                    out_q[i] <= wr_data[3'(i % 8)];
                end else if (wr_toggle && addr[1:0] == 2'(i / 8)) begin
                    out_q[i] <= out_q[i] ^ wr_data[3'(i % 8)];
                end
            end
        end
    end

    logic [31:0] level_w, edge_w, out_w, irq_en_w;
    logic [7:0]  rd_byte;

    always_comb begin
        level_w  = '0;
        edge_w   = '0;
        out_w    = '0;
        irq_en_w = '0;
        level_w[N_IN-1:0]  = level;
        edge_w[N_IN-1:0]   = edge_q;
        out_w[N_OUT-1:0]   = out_q;
        irq_en_w[N_IN-1:0] = irq_en_q;
    end

    // TOGGLE and the unused tail of the window fall through to zero.
    always_comb begin
        rd_byte = '0;
        if (is_field(addr, ADDR_LEVEL)) begin
            rd_byte = field_byte(level_w, addr[1:0]);
        end else if (is_field(addr, ADDR_EDGE)) begin
            rd_byte = field_byte(edge_w, addr[1:0]);
        end else if (is_field(addr, ADDR_OUT)) begin
            rd_byte = field_byte(out_w, addr[1:0]);
        end else if (is_field(addr, ADDR_IRQ_EN)) begin
            rd_byte = field_byte(irq_en_w, addr[1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_byte;
            end
        end
    end

endmodule

// File: tb/tb_mmio_gpio.sv
// Bench for mmio_gpio: directed scenarios plus randomized traffic against a window-based reference model.
module tb_mmio_gpio;

    localparam int NI = 10;
    localparam int NO = 10;
    localparam int DB = 4;
    localparam logic [31:0] IN_MASK  = 32'((64'd1 << NI) - 1);
    localparam logic [31:0] OUT_MASK = 32'((64'd1 << NO) - 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [4:0]    addr = '0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [NI-1:0] pins_in = '0;
    logic [NO-1:0] pins_out;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    mmio_gpio #(
        .N_IN(NI),
        .N_OUT(NO),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .pins_in (pins_in),
        .pins_out(pins_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a channel's level flips once the pin, seen two edges late,
    // has disagreed with the current level for the last DB samples.
    logic [31:0] m_level, m_edge, m_out, m_ien, m_next_level, m_rise, m_wmask, m_lane;
    logic        m_irq, m_rd_valid, m_stable;
    logic [7:0]  m_rd_data;
    logic [31:0] samp_q[$];

    function automatic logic [7:0] m_read(input logic [4:0] a);
        logic [31:0] f;
        case (a[4:2])
            3'd0:    f = m_level;
            3'd1:    f = m_edge;
            3'd2:    f = m_out;
            3'd4:    f = m_ien;
            default: f = '0;
        endcase
        return 8'(f >> (8 * a[1:0]));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_level = '0; m_edge = '0; m_out = '0; m_ien = '0;
            m_irq = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
            samp_q.delete();
            for (int k = 0; k < DB + 2; k++) samp_q.push_back('0);
        end else begin
            if (rd_en) m_rd_data = m_read(addr);
            m_rd_valid = rd_en;
            m_irq = |(m_edge & m_ien);
            samp_q.push_back(32'(pins_in));
            void'(samp_q.pop_front());
            m_next_level = m_level;
            for (int ch = 0; ch < NI; ch++) begin
                m_stable = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (samp_q[k][ch] == m_level[ch]) m_stable = 1'b0;
                if (m_stable) m_next_level[ch] = ~m_level[ch];
            end
            m_rise  = m_next_level & ~m_level;
            m_wmask = 32'(wr_data) << (8 * addr[1:0]);
            m_lane  = 32'hFF << (8 * addr[1:0]);
            if (wr_en) begin
                case (addr[4:2])
                    3'd1:    m_edge = m_edge & ~m_wmask;
                    3'd2:    m_out  = (m_out & ~m_lane) | m_wmask;
                    3'd3:    m_out  = m_out ^ m_wmask;
                    3'd4:    m_ien  = (m_ien & ~m_lane) | m_wmask;
                    default: ;
                endcase
            end
            m_edge  = (m_edge | m_rise) & IN_MASK;
            m_out   = m_out & OUT_MASK;
            m_ien   = m_ien & IN_MASK;
            m_level = m_next_level;
        end
    end

    // One bus cycle: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic cycle(input logic we, input logic [4:0] a, input logic [7:0] wd, input logic re);
        @(negedge clk);
        wr_en = we; addr = a; wr_data = wd; rd_en = re;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'h00, 8'h00, 1'b0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        pins_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (pins_out !== '0) begin n_err++; $display("FAIL reset_pins_out got %h want 0", pins_out); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_glitch;
        pins_in[3] = 1'b1;
        idle(3);
        pins_in[3] = 1'b0;
        idle(8);
        cycle(1'b0, 5'h00, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL glitch_level got %h want 00", rd_data); end
        cycle(1'b0, 5'h04, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL glitch_edge got %h want 00", rd_data); end
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL glitch_rd_valid got %b want 1", rd_valid); end
        idle(1);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL idle_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rd_data_hold got %h want 00", rd_data); end
    endtask

    task automatic test_out_toggle;
        cycle(1'b1, 5'h08, 8'hA5, 1'b0);
        n_cmp++; if (pins_out !== 10'h0A5) begin n_err++; $display("FAIL out_write got %h want 0a5", pins_out); end
        cycle(1'b1, 5'h0C, 8'hFF, 1'b0);
        n_cmp++; if (pins_out[7:0] !== 8'h5A) begin n_err++; $display("FAIL toggle got %h want 5a", pins_out[7:0]); end
        cycle(1'b0, 5'h08, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h5A) begin n_err++; $display("FAIL out_read got %h want 5a", rd_data); end
        cycle(1'b0, 5'h0C, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL toggle_read got %h want 00", rd_data); end
        cycle(1'b1, 5'h09, 8'hFF, 1'b0);
        n_cmp++; if (pins_out !== 10'h35A) begin n_err++; $display("FAIL out_hi_byte got %h want 35a", pins_out); end
        cycle(1'b0, 5'h09, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h03) begin n_err++; $display("FAIL out_hi_read got %h want 03", rd_data); end
        cycle(1'b1, 5'h0B, 8'hFF, 1'b0);
        cycle(1'b1, 5'h14, 8'hFF, 1'b0);
        cycle(1'b0, 5'h0B, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL out_unused_byte got %h want 00", rd_data); end
        cycle(1'b0, 5'h14, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL unmapped_read got %h want 00", rd_data); end
        n_cmp++; if (pins_out !== 10'h35A) begin n_err++; $display("FAIL unmapped_write got %h want 35a", pins_out); end
        cycle(1'b1, 5'h08, 8'h11, 1'b1);
        n_cmp++; if (rd_data !== 8'h5A) begin n_err++; $display("FAIL rd_wr_same got %h want 5a", rd_data); end
        cycle(1'b0, 5'h08, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h11) begin n_err++; $display("FAIL rd_after_wr got %h want 11", rd_data); end
    endtask

    task automatic test_rise_irq;
        cycle(1'b1, 5'h10, 8'h01, 1'b0);
        cycle(1'b1, 5'h04, 8'hFF, 1'b0);
        pins_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, (k == 8) ? 5'h04 : 5'h00, 8'h00, 1'b1);
            n_cmp++; if (rd_data !== m_rd_data) begin n_err++; $display("FAIL rise_model k=%0d got %h want %h", k, rd_data, m_rd_data); end
            if (k == 6) begin
                n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rise_early got %h want 00", rd_data); end
                n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got %b want 0", irq); end
            end
            if (k == 7) begin
                n_cmp++; if (rd_data !== 8'h01) begin n_err++; $display("FAIL rise_level got %h want 01", rd_data); end
                n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set got %b want 1", irq); end
            end
            if (k == 8) begin
                n_cmp++; if (rd_data !== 8'h01) begin n_err++; $display("FAIL rise_edge got %h want 01", rd_data); end
            end
        end
        cycle(1'b0, 5'h04, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h01) begin n_err++; $display("FAIL read_no_clear got %h want 01", rd_data); end
        cycle(1'b1, 5'h04, 8'h01, 1'b0);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_w1c_lag got %b want 1", irq); end
        idle(1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared got %b want 0", irq); end
    endtask

    task automatic test_w1c_race;
        pins_in[1] = 1'b1;
        idle(5);
        cycle(1'b1, 5'h04, 8'h02, 1'b0);
        cycle(1'b0, 5'h04, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h02) begin n_err++; $display("FAIL w1c_race got %h want 02", rd_data); end
        cycle(1'b1, 5'h04, 8'h00, 1'b0);
        cycle(1'b0, 5'h04, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h02) begin n_err++; $display("FAIL w1c_zero got %h want 02", rd_data); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 5'h08, 8'hFF, 1'b0);
        pins_in[2] = 1'b1;
        idle(3);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (pins_out !== '0) begin n_err++; $display("FAIL async_reset_out got %h want 0", pins_out); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL async_reset_irq got %b want 0", irq); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cycle(1'b0, 5'h08, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL out_after_reset got %h want 00", rd_data); end
        for (int k = 2; k <= 8; k++) begin
            cycle(1'b0, (k == 8) ? 5'h04 : 5'h00, 8'h00, 1'b1);
            n_cmp++; if (rd_data !== m_rd_data) begin n_err++; $display("FAIL held_model k=%0d got %h want %h", k, rd_data, m_rd_data); end
            if (k == 6) begin
                n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL held_early got %h want 00", rd_data); end
            end
            if (k == 7) begin
                n_cmp++; if (rd_data !== 8'h07) begin n_err++; $display("FAIL held_level got %h want 07", rd_data); end
            end
            if (k == 8) begin
                n_cmp++; if (rd_data !== 8'h07) begin n_err++; $display("FAIL held_edge got %h want 07", rd_data); end
            end
        end
    endtask

    task automatic test_random;
        logic [4:0] a;
        for (int c = 0; c < 600; c++) begin
            for (int ch = 0; ch < NI; ch++)
                if ($urandom_range(0, 11) == 0) pins_in[ch] = ~pins_in[ch];
            a = 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 2) == 0), a, 8'($urandom), ($urandom_range(0, 1) == 1));
            n_cmp++; if (rd_valid !== m_rd_valid) begin n_err++; $display("FAIL rnd_rd_valid c=%0d got %b want %b", c, rd_valid, m_rd_valid); end
            n_cmp++; if (rd_data !== m_rd_data) begin n_err++; $display("FAIL rnd_rd_data c=%0d got %h want %h", c, rd_data, m_rd_data); end
            n_cmp++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq c=%0d got %b want %b", c, irq, m_irq); end
            n_cmp++; if (32'(pins_out) !== m_out) begin n_err++; $display("FAIL rnd_pins_out c=%0d got %h want %h", c, pins_out, m_out); end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_out_toggle();
        test_rise_irq();
        test_w1c_race();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
